// File: rtl/counter_pkg.sv
// Shared constants for the counter family.
package counter_pkg;

    localparam int DEFAULT_CNT_WIDTH = 4;

endpackage : counter_pkg

// File: rtl/counter_4.sv
// Binary up/down counter with count enable. Wraps modulo 2^WIDTH in both
// directions, asynchronous active-high clear.
module counter_4
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic             en,
    input  logic             ud,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Plain modular add/subtract gives the wrap-around for free.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (ud) count_d = count_q + ONE;
            else    count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule : counter_4

// File: tb/tb_counter_4.sv
// Self-checking bench for counter_4: vector table driven through a scoreboard
// queue, plus hand sequences for reset behaviour.
module tb_counter_4;

    typedef struct {
        logic       en;
        logic       ud;
        logic [3:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ud;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;
    int popped   = 0;

    logic [3:0] exp_q[$];
    vec_t       vecs[$];

    counter_4 #(.WIDTH(4)) dut (
        .en   (en),
        .ud   (ud),
        .clk  (clk),
        .rst  (rst),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: count=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard side: one expected value per clock edge, compared 1 ns after it.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            chk($sformatf("edge%0d", popped), count, e);
            popped++;
        end
    end

    initial begin
        // Up 1..15, wrap to 0 then 1, up to 5
        for (int i = 1; i <= 15; i++) vecs.push_back('{1'b1, 1'b1, 4'(i)});
        vecs.push_back('{1'b1, 1'b1, 4'd0});
        for (int i = 1; i <= 5; i++) vecs.push_back('{1'b1, 1'b1, 4'(i)});
        // Down from 5 through the wrap: 4,3,2,1,0,15,14 then on to 9
        for (int i = 4; i >= 0; i--) vecs.push_back('{1'b1, 1'b0, 4'(i)});
        for (int i = 15; i >= 9; i--) vecs.push_back('{1'b1, 1'b0, 4'(i)});
        // Hold at 9 for five edges with ud toggling, then resume up
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 1'(i % 2), 4'd9});
        vecs.push_back('{1'b1, 1'b1, 4'd10});
        // Down to 7 for the async reset sequence
        for (int i = 9; i >= 7; i--) vecs.push_back('{1'b1, 1'b0, 4'(i)});

        rst = 1'b1; en = 1'b1; ud = 1'b1;
        #2;
        chk("reset_before_edge", count, 4'd0);
        @(posedge clk); #1;
        chk("reset_after_edge", count, 4'd0);
        @(posedge clk); #1;
        chk("reset_after_edge2", count, 4'd0);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            en = vecs[i].en;
            ud = vecs[i].ud;
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
        end

        // Async clear between edges at count=7
        chk("pre_async", count, 4'd7);
        rst = 1'b1;
        #1;
        chk("async_clear", count, 4'd0);
        en = 1'b1; ud = 1'b1;
        exp_q.push_back(4'd0);
        @(negedge clk);
        en = 1'b0; ud = 1'b0;
        exp_q.push_back(4'd0);
        @(negedge clk);

        // Release with down count: 0 -> 15 -> 14
        rst = 1'b0; en = 1'b1; ud = 1'b0;
        exp_q.push_back(4'd15);
        @(negedge clk);
        exp_q.push_back(4'd14);
        @(negedge clk);
        ud = 1'b1;
        exp_q.push_back(4'd15);
        @(negedge clk);
        exp_q.push_back(4'd0);
        @(negedge clk);

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_counter_4
